// File: rtl/bitonic_sort_sched_if.sv
// Purpose: stream bundle for bitonic_sort_sched (frame in, sorted frame out, status).
// Latency: none, wiring only.
// Backpressure: in_ready/out_ready follow plain valid-ready rules.
// Ports: in_valid/in_ready/in_data/desc (load side), out_valid/out_ready/out_data/out_last
//        (drain side), busy (status). master = traffic source/sink, slave = sorter.
`timescale 1ns/1ps
interface bitonic_sort_sched_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  desc;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;
    logic                  busy;

    modport master (
        output in_valid, in_data, desc, out_ready,
        input  in_ready, out_valid, out_data, out_last, busy
    );

    modport slave (
        input  in_valid, in_data, desc, out_ready,
        output in_ready, out_valid, out_data, out_last, busy
    );
endinterface

// File: rtl/bitonic_sort_sched.sv
// Purpose: area-lean bitonic sorter, every compare-exchange serialised through one comparator.
// Latency: first sorted beat 2*C cycles after the last input beat (C = N/2*LOG_N*(LOG_N+1)/2).
// Backpressure: in_ready only in LOAD; output word held while out_ready is low.
// Ports: clk, reset (sync, active-high), bus (bitonic_sort_sched_if.slave).
`timescale 1ns/1ps

// One-cycle registered compare-exchange. POLARITY=0: h=min, l=max; on a tie h=b, l=a.
module bitonic_comp #(
    parameter int W        = 8,
    parameter bit POLARITY = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         valid,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         done,
    output logic [W-1:0] h,
    output logic [W-1:0] l
);
    logic sel_a;
    assign sel_a = POLARITY ? (a > b) : (a < b);

    always_ff @(posedge clk) begin
        if (reset) begin
            done <= 1'b0;
            h    <= '0;
            l    <= '0;
        end else begin
            done <= valid;
            if (valid) begin
                h <= sel_a ? a : b;
                l <= sel_a ? b : a;
            end
        end
    end
endmodule

module bitonic_sort_sched #(
    parameter int DATA_WIDTH = 8,
    parameter int LOG_N      = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    bitonic_sort_sched_if.slave   bus
);
    localparam int N  = 1 << LOG_N;
    localparam int CW = LOG_N;
    localparam int SW = (LOG_N > 1) ? $clog2(LOG_N) : 1;

    typedef enum logic [1:0] {LOAD, ISSUE, WB, OUT} state_t;

    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] mem [N];
    logic [CW-1:0]         lcnt, ocnt, pcnt;
    logic [SW-1:0]         scnt;   // log2(j)
    logic [SW-1:0]         kcnt;   // log2(k)-1
    logic                  desc_q;

    logic                  cmp_vld, cmp_done;
    logic [DATA_WIDTH-1:0] cmp_h, cmp_l;

    logic [CW-1:0]         j_v, k_v, idx_i, idx_l;
    logic                  up, last_p, last_s, last_k, last_beat;

    // Pair indices. Everything fits in CW bits: i < N, and k == N on the last
    // stage truncates to 0, which gives (i & k) == 0 exactly as the full width would.
    always_comb begin
        j_v    = CW'(1) << scnt;
        k_v    = CW'(2) << kcnt;
        idx_i  = (((pcnt >> scnt) << scnt) << 1) | (pcnt & (j_v - CW'(1)));
        idx_l  = idx_i | j_v;
        up     = ((idx_i & k_v) == '0) ^ desc_q;
        last_p = (pcnt == CW'(N / 2 - 1));
        last_s = (scnt == '0);
        last_k = (kcnt == SW'(LOG_N - 1));
    end

    assign last_beat = (ocnt == CW'(N - 1));

    bitonic_comp #(.W(DATA_WIDTH), .POLARITY(1'b0)) u_comp (
        .clk   (clk),
        .reset (reset),
        .valid (cmp_vld),
        .a     (mem[idx_i]),
        .b     (mem[idx_l]),
        .done  (cmp_done),
        .h     (cmp_h),
        .l     (cmp_l)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= LOAD;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        bus.in_ready = 1'b0;
        bus.busy     = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_last = 1'b0;
        cmp_vld      = 1'b0;
        case (state)
            LOAD: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid && lcnt == CW'(N - 1)) state_nxt = ISSUE;
            end
            ISSUE: begin
                bus.busy  = 1'b1;
                cmp_vld   = 1'b1;
                state_nxt = WB;
            end
            WB: begin
                bus.busy  = 1'b1;
                state_nxt = (last_p && last_s && last_k) ? OUT : ISSUE;
            end
            OUT: begin
                bus.busy      = 1'b1;
                bus.out_valid = 1'b1;
                bus.out_last  = last_beat;
                if (bus.out_ready && last_beat) state_nxt = LOAD;
            end
            default: state_nxt = LOAD;
        endcase
    end

    assign bus.out_data = mem[ocnt];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int n = 0; n < N; n++) mem[n] <= '0;
            lcnt   <= '0;
            ocnt   <= '0;
            pcnt   <= '0;
            scnt   <= '0;
            kcnt   <= '0;
            desc_q <= 1'b0;
        end else begin
            if (state == LOAD && bus.in_valid) begin
                mem[lcnt] <= bus.in_data;
                if (lcnt == '0) desc_q <= bus.desc;
                lcnt <= (lcnt == CW'(N - 1)) ? '0 : lcnt + 1'b1;
            end
            if (state == WB && cmp_done) begin
                mem[idx_i] <= up ? cmp_h : cmp_l;
                mem[idx_l] <= up ? cmp_l : cmp_h;
                // p fastest, then j (descending), then k; new stage starts at j = k/2.
                if (!last_p) begin
                    pcnt <= pcnt + 1'b1;
                end else begin
                    pcnt <= '0;
                    if (!last_s) begin
                        scnt <= scnt - 1'b1;
                    end else if (!last_k) begin
                        kcnt <= kcnt + 1'b1;
                        scnt <= kcnt + 1'b1;
                    end else begin
                        kcnt <= '0;
                        scnt <= '0;
                    end
                end
            end
            if (state == OUT && bus.out_ready)
                ocnt <= last_beat ? '0 : ocnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_bitonic_sort_sched.sv
`timescale 1ns/1ps
module tb_bitonic_sort_sched;
    typedef logic [7:0] frame_t [8];
    typedef logic [8:0] exp_t;   // {last, data}

    logic clk;
    logic reset;
    int   cyc;
    int   checks;
    int   failures;
    exp_t exp_q[$];

    int   last_acc, first_acc, last_hs;
    int   beat_cnt;
    bit   stall_mode;
    bit   stalled [8];

    bitonic_sort_sched_if #(.DATA_WIDTH(8)) bus ();

    bitonic_sort_sched #(.DATA_WIDTH(8), .LOG_N(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
    endtask

    // Monitor / scoreboard: pops on every output handshake, also checks hold-while-stalled.
    initial begin : monitor
        bit         held_vld;
        logic [7:0] held_dat;
        exp_t       e;
        held_vld = 0;
        held_dat = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                held_vld = 0;
                beat_cnt = 0;
            end else begin
                chk("busy_vs_ready", int'(bus.busy), int'(!bus.in_ready));
                if (bus.out_valid) begin
                    if (held_vld) chk("stall_hold", int'(bus.out_data), int'(held_dat));
                    if (bus.out_ready) begin
                        if (exp_q.size() == 0) begin
                            fail_now("unexpected_beat");
                        end else begin
                            e = exp_q.pop_front();
                            chk("out_data", int'(bus.out_data), int'(e[7:0]));
                            chk("out_last", int'(bus.out_last), int'(e[8]));
                        end
                        held_vld = 0;
                        if (bus.out_last) begin
                            beat_cnt = 0;
                            last_hs  = cyc + 1;
                        end else begin
                            beat_cnt++;
                        end
                    end else begin
                        held_vld = 1;
                        held_dat = bus.out_data;
                    end
                end
            end
        end
    end

    // Sink: in stall mode drop out_ready for 3 cycles when beats 0, 4 and 7 are presented.
    initial begin : sink
        forever begin
            @(posedge clk);
            #1;
            if (stall_mode && bus.out_valid && bus.out_ready &&
                (beat_cnt == 0 || beat_cnt == 4 || beat_cnt == 7) && !stalled[beat_cnt]) begin
                stalled[beat_cnt] = 1;
                bus.out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        end
    end

    task automatic send_frame(input frame_t d, input logic dsc, input bit gaps,
                              input bit hold, input bit push, input frame_t e);
        int t;
        if (push)
            for (int b = 0; b < 8; b++) exp_q.push_back({(b == 7), e[b]});
        for (int b = 0; b < 8; b++) begin
            if (gaps) begin
                bus.in_valid = 1'b0;
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
            bus.in_valid = 1'b1;
            bus.in_data  = d[b];
            bus.desc     = (b == 0) ? dsc : ~dsc;   // later beats must not matter
            t = 0;
            forever begin
                @(negedge clk);
                if (bus.in_ready) break;
                t++;
                if (t > 400) begin
                    fail_now("in_ready_wait");
                    break;
                end
            end
            @(posedge clk);
            #1;
            if (b == 0) first_acc = cyc;
            last_acc = cyc;
        end
        bus.in_valid = hold;
        bus.in_data  = 8'h00;
        bus.desc     = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) fail_now("drain");
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        frame_t fi, fo;
        int t;
        checks = 0; failures = 0; cyc = 0;
        last_acc = 0; first_acc = 0; last_hs = 0; beat_cnt = 0;
        stall_mode = 0;
        for (int b = 0; b < 8; b++) stalled[b] = 0;
        bus.in_valid = 0; bus.in_data = 0; bus.desc = 0; bus.out_ready = 1;
        reset = 1;
        repeat (3) @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        chk("rst_in_ready", int'(bus.in_ready), 1);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_out_last", int'(bus.out_last), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_out_data", int'(bus.out_data), 0);
        @(posedge clk);
        #1;

        // Ascending, with first-beat latency check.
        fi = '{8'd7, 8'd3, 8'd0, 8'd255, 8'd12, 8'd12, 8'd1, 8'd200};
        fo = '{8'd0, 8'd1, 8'd3, 8'd7, 8'd12, 8'd12, 8'd200, 8'd255};
        send_frame(fi, 1'b0, 0, 0, 1, fo);
        t = 0;
        while (!bus.out_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (bus.out_valid) chk("latency", cyc - last_acc, 48);
        else fail_now("latency");
        drain();

        // Descending, desc toggled after the first beat.
        fo = '{8'd255, 8'd200, 8'd12, 8'd12, 8'd7, 8'd3, 8'd1, 8'd0};
        send_frame(fi, 1'b1, 0, 0, 1, fo);
        drain();

        // All equal, with in_valid held high through ISSUE/WB/OUT.
        fi = '{8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A};
        send_frame(fi, 1'b0, 0, 1, 1, fi);
        t = 0;
        forever begin
            @(negedge clk);
            chk("in_ready_blocked", int'(bus.in_ready), 0);
            if (bus.out_valid && bus.out_last && bus.out_ready) begin
                bus.in_valid = 1'b0;
                break;
            end
            t++;
            if (t > 200) begin
                fail_now("hold_wait");
                bus.in_valid = 1'b0;
                break;
            end
        end
        drain();

        // Already sorted and reverse sorted.
        fi = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80};
        send_frame(fi, 1'b0, 0, 0, 1, fi);
        drain();
        fo = fi;
        fi = '{8'd80, 8'd70, 8'd60, 8'd50, 8'd40, 8'd30, 8'd20, 8'd10};
        send_frame(fi, 1'b0, 0, 0, 1, fo);
        drain();

        // Input gaps plus output stalls at beats 0, 4, 7.
        stall_mode = 1;
        fi = '{8'd9, 8'd250, 8'd4, 8'd4, 8'd100, 8'd0, 8'd33, 8'd17};
        fo = '{8'd0, 8'd4, 8'd4, 8'd9, 8'd17, 8'd33, 8'd100, 8'd250};
        send_frame(fi, 1'b0, 1, 0, 1, fo);
        drain();
        stall_mode = 0;
        chk("stalls_seen", int'(stalled[0]) + int'(stalled[4]) + int'(stalled[7]), 3);

        // Reset during WB of compare 10, then a clean frame.
        fi = '{8'd99, 8'd1, 8'd250, 8'd3, 8'd77, 8'd5, 8'd6, 8'd200};
        send_frame(fi, 1'b1, 0, 0, 0, fi);
        repeat (19) @(posedge clk);
        @(negedge clk);
        chk("busy_before_reset", int'(bus.busy), 1);
        reset = 1;
        @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        chk("rst2_in_ready", int'(bus.in_ready), 1);
        chk("rst2_out_valid", int'(bus.out_valid), 0);
        chk("rst2_out_last", int'(bus.out_last), 0);
        chk("rst2_busy", int'(bus.busy), 0);
        chk("rst2_out_data", int'(bus.out_data), 0);
        @(posedge clk);
        #1;
        fi = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        fo = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        send_frame(fi, 1'b0, 0, 0, 1, fo);
        drain();

        // Back-to-back frames, out_ready tied high.
        fi = '{8'd5, 8'd1, 8'd4, 8'd2, 8'd8, 8'd6, 8'd7, 8'd3};
        fo = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        send_frame(fi, 1'b1, 0, 0, 1, fo);
        fi = '{8'd200, 8'd100, 8'd150, 8'd50, 8'd250, 8'd0, 8'd25, 8'd75};
        fo = '{8'd0, 8'd25, 8'd50, 8'd75, 8'd100, 8'd150, 8'd200, 8'd250};
        send_frame(fi, 1'b0, 0, 0, 1, fo);
        chk("b2b_gap", first_acc - last_hs, 1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
